// File: rtl/onehot_scan_decoder.sv
// Registered, handshaked one-hot decoder: DIRECT single-index decode or SCAN walk across a wrapping window.
// Define ONEHOT_SCAN_ABORT_EN to add an abort input that terminates an active command early.
module onehot_scan_decoder #(
  parameter int unsigned OUT_DW = 8,
  parameter int unsigned IN_DW  = $clog2(OUT_DW)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ONEHOT_SCAN_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [IN_DW-1:0]  in_data,
  input  logic [IN_DW:0]    in_len,
  output logic [OUT_DW-1:0] dec_out,
  output logic              dec_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned      LEN_W    = IN_DW + 1;
  localparam logic [LEN_W-1:0] OUT_DW_L = LEN_W'(OUT_DW);
  localparam logic [IN_DW-1:0] LAST_POS = IN_DW'(OUT_DW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIRECT_OUT,
    S_SCAN
  } state_t;

  state_t            state, state_d;
  logic [IN_DW-1:0]  pos, pos_d, pos_inc;
  logic [LEN_W-1:0]  remain, remain_d, eff_len;
  logic [OUT_DW-1:0] dec_d;
  logic              valid_d, busy_d, done_d, err_d;
  logic              abort_req, accept, xfer, in_range;

`ifdef ONEHOT_SCAN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign in_ready = (state == S_IDLE) & ~rst;
  assign accept   = in_valid & in_ready;
  assign xfer     = dec_valid & out_ready;
  assign in_range = LEN_W'(in_data) < OUT_DW_L;
  // Zero length and anything beyond the window both mean a full sweep.
  assign eff_len  = ((in_len == '0) || (in_len > OUT_DW_L)) ? OUT_DW_L : in_len;
  // Explicit wrap keeps non-power-of-two windows correct without a modulo.
  assign pos_inc  = (pos == LAST_POS) ? '0 : pos + IN_DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pos       <= '0;
      remain    <= '0;
      dec_out   <= '0;
      dec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      pos       <= pos_d;
      remain    <= remain_d;
      dec_out   <= dec_d;
      dec_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d  = state;
    pos_d    = pos;
    remain_d = remain;
    dec_d    = dec_out;
    valid_d  = dec_valid;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (!in_mode) begin
            dec_d   = in_range ? (OUT_DW'(1) << in_data) : '0;
            valid_d = 1'b1;
            err_d   = ~in_range;
            state_d = S_DIRECT_OUT;
          end else if (!in_range) begin
            err_d = 1'b1;
          end else begin
            pos_d    = in_data;
            remain_d = eff_len;
            dec_d    = OUT_DW'(1) << in_data;
            valid_d  = 1'b1;
            state_d  = S_SCAN;
          end
        end
      end

      S_DIRECT_OUT: begin
        if (abort_req || xfer) begin
          dec_d   = '0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_SCAN: begin
        if (abort_req || (xfer && (remain <= LEN_W'(1)))) begin
          dec_d   = '0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (xfer) begin
          pos_d    = pos_inc;
          dec_d    = OUT_DW'(1) << pos_inc;
          remain_d = remain - LEN_W'(1);
        end
      end

      default: begin
        dec_d   = '0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
